// File: rtl/seq_alu_hs_if.sv
// Handshake bundle for seq_alu_hs: operand/opcode in, registered result and flags out.
interface seq_alu_hs_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c;
  logic [2:0]       opc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] W;
  logic             zer;
  logic             neg;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, A, B, c, opc, out_ready,
    input  in_ready, out_valid, W, zer, neg, cout, ovf
  );

  modport slave (
    input  in_valid, A, B, c, opc, out_ready,
    output in_ready, out_valid, W, zer, neg, cout, ovf
  );
endinterface

// File: rtl/seq_alu_hs.sv
// Clocked ALU with valid/ready handshake and a multi-cycle shift-add multiply.
//
// state | meaning
// IDLE  | ready for an operand bundle
// BUSY  | shift-add multiply iterating, cnt iterations left
// DONE  | result and flags held until the consumer takes them
module seq_alu_hs #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         rst,
  seq_alu_hs_if.slave bus
);
  localparam int MSB = WIDTH - 1;
  localparam int H   = WIDTH / 2;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_ci;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_w;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] acc_next;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

  // Shared adder: operand selection per opcode, then one WIDTH+1 bit sum.
  always_comb begin
    add_a  = bus.A;
    add_b  = '0;
    add_ci = 1'b0;
    case (bus.opc)
      3'b000: begin add_a = ~bus.A; add_ci = 1'b1; end
      3'b001: add_ci = 1'b1;
      3'b010: begin add_b = bus.B; add_ci = bus.c; end
      3'b011: add_b = bus.B >> 1;
      default: ;
    endcase
    sum     = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
    add_ovf = (add_a[MSB] == add_b[MSB]) && (sum[MSB] != add_a[MSB]);
  end

  // Result and flag selection for the single-cycle operations.
  always_comb begin
    alu_w = sum[WIDTH-1:0];
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.opc)
      3'b000: alu_v = (bus.A == {1'b1, {(WIDTH-1){1'b0}}});
      3'b001, 3'b010, 3'b011: begin
        alu_c = sum[WIDTH];
        alu_v = add_ovf;
      end
      3'b100: alu_w = bus.A & bus.B;
      3'b101: alu_w = bus.A | bus.B;
      3'b110: alu_w = {bus.A[H-1:0], bus.B[H-1:0]};
      default: alu_w = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  // Handshake FSM with registered result, flags and multiply datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      bus.W    <= '0;
      bus.zer  <= 1'b0;
      bus.neg  <= 1'b0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.opc == 3'b111) begin
              mcand  <= bus.A;
              mplier <= bus.B;
              acc    <= '0;
              cnt    <= CW'(WIDTH);
              state  <= BUSY;
            end else begin
              bus.W    <= alu_w;
              bus.zer  <= (alu_w == '0);
              bus.neg  <= alu_w[MSB];
              bus.cout <= alu_c;
              bus.ovf  <= alu_v;
              state    <= DONE;
            end
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bus.W    <= acc_next;
            bus.zer  <= (acc_next == '0);
            bus.neg  <= acc_next[MSB];
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu_hs.sv
// Self-checking bench for seq_alu_hs: directed table, corner sequences, random vs. model.
module tb_seq_alu_hs;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_alu_hs_if #(.WIDTH(WIDTH)) bus ();
  seq_alu_hs #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [2:0]  opc;
    logic [15:0] w;
    logic        z;
    logic        n;
    logic        co;
    logic        v;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model from the arithmetic definitions: returns {w, zer, neg, cout, ovf}.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic [2:0] opc);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r  = 0;
    longint sr = 0;
    logic co = 1'b0;
    logic v  = 1'b0;
    logic [15:0] w;
    case (opc)
      3'd0: begin r = 65536 - ua; v = (sa == -32768); end
      3'd1: begin r = ua + 1; sr = sa + 1; co = (r > 65535); v = (sr > 32767); end
      3'd2: begin
        r = ua + ub + longint'(c); sr = sa + sb + longint'(c);
        co = (r > 65535); v = (sr > 32767) || (sr < -32768);
      end
      3'd3: begin
        r = ua + ub / 2; sr = sa + ub / 2;
        co = (r > 65535); v = (sr > 32767);
      end
      3'd4: r = longint'(a & b);
      3'd5: r = longint'(a | b);
      3'd6: r = (ua % 256) * 256 + (ub % 256);
      default: r = ua * ub;
    endcase
    w = 16'(r % 65536);
    return {w, (w == 16'h0), (w >= 16'h8000), co, v};
  endfunction

  // Issue one operation; optionally poke in_valid with junk while waiting.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [2:0] opc, input bit poke,
                        output logic [19:0] res, output int lat);
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.A = a; bus.B = b; bus.c = c; bus.opc = opc; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A = 16'($urandom); bus.B = 16'($urandom); bus.c = 1'($urandom); bus.opc = 3'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      if (poke) begin
        if (bus.in_ready !== 1'b0) begin
          errors++; checks++;
          $display("FAIL in_ready_busy got=%0h exp=0", bus.in_ready);
        end
        bus.in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    res = {bus.W, bus.zer, bus.neg, bus.cout, bus.ovf};
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("idle_after_take", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
  endtask

  logic [19:0] res;
  logic [19:0] hold;
  int lat;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.c = 1'b0; bus.opc = '0;

    vt[0]  = '{16'h7FFF, 16'h0001, 1'b0, 3'd2, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{16'hFFFF, 16'h0001, 1'b1, 3'd2, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{16'h8000, 16'h0000, 1'b0, 3'd0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{16'h1234, 16'hABCD, 1'b0, 3'd6, 16'h34CD, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{16'hFFFD, 16'h0007, 1'b0, 3'd7, 16'hFFEB, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{16'hF0F0, 16'hFF00, 1'b0, 3'd4, 16'hF000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{16'h7FFF, 16'h0000, 1'b1, 3'd1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[8]  = '{16'hFFFF, 16'h0000, 1'b1, 3'd1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{16'h0001, 16'hFFFF, 1'b1, 3'd3, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[10] = '{16'h00F0, 16'h0F00, 1'b1, 3'd5, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{16'h0001, 16'h1234, 1'b1, 3'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset for two edges.
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("reset_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    check("reset_w", 32'(bus.W), 32'h0);
    check("reset_flags", {28'd0, bus.zer, bus.neg, bus.cout, bus.ovf}, 32'h0);
    @(posedge clk); #1;

    // Directed table.
    foreach (vt[i]) begin
      run_op(vt[i].a, vt[i].b, vt[i].c, vt[i].opc, 1'b0, res, lat);
      check($sformatf("vec%0d_w", i), 32'(res[19:4]), 32'(vt[i].w));
      check($sformatf("vec%0d_flags", i), 32'(res[3:0]),
            {28'd0, vt[i].z, vt[i].n, vt[i].co, vt[i].v});
      check($sformatf("vec%0d_lat", i), 32'(lat), (vt[i].opc == 3'd7) ? 32'd17 : 32'd1);
    end

    // Multiply with in_valid pulses during BUSY.
    run_op(16'hFFFD, 16'h0007, 1'b0, 3'd7, 1'b1, res, lat);
    check("mul_poke_w", 32'(res[19:4]), 32'hFFEB);
    check("mul_poke_lat", 32'(lat), 32'd17);

    // Result held for 5 cycles with out_ready low.
    bus.A = 16'h7FFF; bus.B = 16'h0001; bus.c = 1'b0; bus.opc = 3'd2; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.A = 16'h0; bus.B = 16'h0;
    for (int k = 0; k < 5; k++) begin
      hold = {bus.W, bus.zer, bus.neg, bus.cout, bus.ovf};
      check("hold_result", 32'(hold), 32'({16'h8000, 4'b0101}));
      check("hold_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'b01);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("hold_release", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);

    // Reset in the middle of a multiply.
    bus.A = 16'h1234; bus.B = 16'h5678; bus.opc = 3'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("busy_before_reset", {30'd0, bus.in_ready, bus.out_valid}, 32'b00);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("reset_busy_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    check("reset_busy_w", 32'(bus.W), 32'h0);
    run_op(16'hF0F0, 16'hFF00, 1'b0, 3'd4, 1'b0, res, lat);
    check("after_reset_and", 32'(res), 32'({16'hF000, 4'b0100}));

    // Random operations against the model.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      logic [2:0]  ro;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); ro = 3'($urandom);
      if (i % 8 == 0) ra = 16'h8000;
      if (i % 8 == 1) rb = 16'hFFFF;
      run_op(ra, rb, rc, ro, 1'b1, res, lat);
      check($sformatf("rand%0d_op%0d_%h_%h_%0d", i, ro, ra, rb, rc), 32'(res),
            32'(model(ra, rb, rc, ro)));
      check($sformatf("rand%0d_lat", i), 32'(lat), (ro == 3'd7) ? 32'd17 : 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
